// File: rtl/dot_product_accumulator.sv
// Accumulates K consecutive unsigned products into a dot-product sum held in a 1-entry valid/ready output slot.
// Optional feature: define DOTACC_SATURATE_EN to clamp sums at all ones and expose out_sat.
module dot_product_accumulator #(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int ACC_W = 2*N + $clog2(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2*N-1:0]   in_product,
    input  logic             clear,
    output logic             in_space,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             overrun
`ifdef DOTACC_SATURATE_EN
    ,
    output logic             out_sat
`endif
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(K - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             overrun_q, overrun_d;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum_next;
    logic             at_last;
    logic             slot_free;

`ifdef DOTACC_SATURATE_EN
    localparam int EXT_W = ((ACC_W > 2*N) ? ACC_W : 2*N) + 1;

    logic             grp_sat_q, grp_sat_d;
    logic             out_sat_q, out_sat_d;
    logic [EXT_W-1:0] sum_ext;
    logic             sat_next;
`endif

    assign at_last   = (cnt_q == LAST_TERM);
    assign slot_free = !out_valid_q || out_ready;
    assign in_space  = !(out_valid_q && !out_ready && at_last);

    // The first term of a group ignores whatever the previous group left in acc.
    always_comb begin
        base = (cnt_q == '0) ? '0 : acc_q;
`ifdef DOTACC_SATURATE_EN
        sum_ext  = EXT_W'(base) + EXT_W'(in_product);
        // Once a group has saturated it stays clamped, even if later terms are zero.
        sat_next = ((cnt_q != '0) && grp_sat_q) || (|sum_ext[EXT_W-1:ACC_W]);
        sum_next = sat_next ? '1 : sum_ext[ACC_W-1:0];
`else
        sum_next = base + ACC_W'(in_product);
`endif
    end

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        overrun_d   = overrun_q;
`ifdef DOTACC_SATURATE_EN
        grp_sat_d   = grp_sat_q;
        out_sat_d   = out_sat_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            if (at_last) begin
                cnt_d = '0;
                if (slot_free) begin
                    out_sum_d   = sum_next;
                    out_valid_d = 1'b1;
`ifdef DOTACC_SATURATE_EN
                    out_sat_d   = sat_next;
`endif
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + 1'b1;
`ifdef DOTACC_SATURATE_EN
                grp_sat_d = sat_next;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            overrun_q   <= 1'b0;
`ifdef DOTACC_SATURATE_EN
            grp_sat_q   <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            overrun_q   <= overrun_d;
`ifdef DOTACC_SATURATE_EN
            grp_sat_q   <= grp_sat_d;
            out_sat_q   <= out_sat_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign overrun   = overrun_q;
`ifdef DOTACC_SATURATE_EN
    assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: a default-width instance plus an ACC_W=8 instance sharing stimulus.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_dot_product_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_product;
    logic       clear;
    logic       out_ready;

    logic       in_space_a,  in_space_b;
    logic       out_valid_a, out_valid_b;
    logic [9:0] out_sum_a;
    logic [7:0] out_sum_b;
    logic       overrun_a,   overrun_b;
`ifdef DOTACC_SATURATE_EN
    logic       out_sat_a,   out_sat_b;
`endif

    int checks = 0;
    int errors = 0;

    dot_product_accumulator #(.N(4), .K(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_product (in_product),
        .clear      (clear),
        .in_space   (in_space_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_sum    (out_sum_a),
        .overrun    (overrun_a)
`ifdef DOTACC_SATURATE_EN
        ,
        .out_sat    (out_sat_a)
`endif
    );

    dot_product_accumulator #(.N(4), .K(4), .ACC_W(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_product (in_product),
        .clear      (clear),
        .in_space   (in_space_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_sum    (out_sum_b),
        .overrun    (overrun_b)
`ifdef DOTACC_SATURATE_EN
        ,
        .out_sat    (out_sat_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle product pulse; returns on the falling edge after the capturing rising edge.
    task automatic pulse(input logic [7:0] p);
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = p;
        @(negedge clk);
        in_valid   = 1'b0;
        in_product = '0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        idle(2);

        check("rst_valid",   out_valid_a, 0);
        check("rst_sum",     out_sum_a,   0);
        check("rst_overrun", overrun_a,   0);
        check("rst_space",   in_space_a,  1);
        @(negedge clk);
        rst = 1'b0;

        // Spaced pulses 3,5,7,9 -> 24, held until out_ready.
        pulse(3); idle(4);
        pulse(5); idle(4);
        pulse(7); idle(4);
        check("t1_not_yet", out_valid_a, 0);
        pulse(9);
        check("t1_valid", out_valid_a, 1);
        check("t1_sum",   out_sum_a,   24);
        idle(3);
        check("t1_hold_valid", out_valid_a, 1);
        check("t1_hold_sum",   out_sum_a,   24);
        drain();
        check("t1_drained", out_valid_a, 0);

        // Largest products at default width: 4*225 = 900.
        repeat (4) pulse(225);
        check("t2_valid",   out_valid_a, 1);
        check("t2_sum",     out_sum_a,   900);
        check("t2_overrun", overrun_a,   0);
`ifdef DOTACC_SATURATE_EN
        check("t2_sat", out_sat_a, 0);
`endif
        drain();
        check("t2_drained", out_valid_a, 0);

        // Full output slot: second group is dropped, third lands while being consumed.
        pulse(1); pulse(2); pulse(3); pulse(4);
        check("t3_a_sum", out_sum_a, 10);
        pulse(5); pulse(5); pulse(5);
        check("t3_space_low", in_space_a, 0);
        pulse(5);
        check("t3_held_sum",  out_sum_a,   10);
        check("t3_held_valid", out_valid_a, 1);
        check("t3_overrun",   overrun_a,   1);
        check("t3_space_back", in_space_a, 1);
        pulse(6); pulse(6); pulse(6);
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = 8'd6;
        out_ready  = 1'b1;
        #1;
        check("t3_space_ready", in_space_a, 1);
        @(negedge clk);
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b0;
        check("t3_swap_valid",   out_valid_a, 1);
        check("t3_swap_sum",     out_sum_a,   24);
        check("t3_overrun_kept", overrun_a,   1);
        drain();
        check("t3_drained", out_valid_a, 0);

        // clear aborts a partial group; clear beats a coincident product.
        pulse(7); pulse(8);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_overrun_untouched", overrun_a, 1);
        pulse(1); pulse(1); pulse(1);
        check("t4_not_yet", out_valid_a, 0);
        pulse(1);
        check("t4_valid", out_valid_a, 1);
        check("t4_sum",   out_sum_a,   4);
        drain();
        @(negedge clk);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'd50;
        @(negedge clk);
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        pulse(2); pulse(2); pulse(2); pulse(2);
        check("t4_clear_wins_valid", out_valid_a, 1);
        check("t4_clear_wins_sum",   out_sum_a,   8);

        // Asynchronous reset mid-group with a loaded output slot.
        pulse(2); pulse(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_valid",   out_valid_a, 0);
        check("t5_rst_sum",     out_sum_a,   0);
        check("t5_rst_overrun", overrun_a,   0);
        check("t5_rst_space",   in_space_a,  1);
        check("t5_rst_valid8",  out_valid_b, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse(2); pulse(2);
        check("t5_partial_gone", out_valid_a, 0);
        pulse(2); pulse(2);
        check("t5_valid",   out_valid_a, 1);
        check("t5_sum",     out_sum_a,   8);
        check("t5_overrun", overrun_a,   0);
        drain();

        // Narrow accumulator: 900 does not fit in 8 bits.
        repeat (4) pulse(225);
        check("t6_valid8",   out_valid_b, 1);
        check("t6_wide_sum", out_sum_a,   900);
`ifdef DOTACC_SATURATE_EN
        check("t6_sum8_sat",  out_sum_b, 255);
        check("t6_sat8",      out_sat_b, 1);
        check("t6_sat_wide",  out_sat_a, 0);
`else
        check("t6_sum8_wrap", out_sum_b, 132);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
